pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter and instruction-fetch controller for the 5-stage RV32I core. It owns the PC register and drives the instruction-memory request. It sequences IF/ID writes, flushes and freezes under memory stalls, load-use hazards and EX-stage redirects (taken branch, JAL, JALR). It supplies `pc_add4`, which the ID-stage PC-to-register select uses as its default link value, and a one-entry skid buffer that keeps fetched words across pipeline freezes.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `im_req` out 1: fetch request. Must be held until `im_ready` (address may not change while pending).
- `im_addr` out 32: fetch address.
- `im_ready` in 1: fetch completes this cycle; `im_rdata` is valid.
- `im_rdata` in 32: fetched instruction.
- `dm_stall` in 1: MEM stage busy; whole pipeline frozen.
- `lu_hazard` in 1: load-use hazard in ID; hold PC and IF/ID, bubble ID/EX.
- `redirect` in 1: EX resolved a control transfer.
- `redirect_pc` in 32: target; bits [1:0] ignored, treated as 2'b00.
- `pc` out 32: address of the instruction being fetched.
- `pc_add4` out 32: `pc + 4`, modulo 2^32.
- `if_inst` out 32: instruction to write into IF/ID.
- `if_pc` out 32: its address.
- `if_id_we` out 1: IF/ID register write enable.
- `if_id_flush` out 1: IF/ID register loads a NOP (32'h0000_0013).
- `id_ex_flush` out 1: ID/EX register loads a bubble.

## Operation
- `freeze = dm_stall | lu_hazard`. `take = redirect & ~dm_stall`.
- States:
  - FETCH: `im_req=1`, `im_addr=pc`.
  - HOLD: word buffered, `im_req=0`.
  - DRAIN: stale fetch pending; `im_req=1`, `im_addr=pc`; the target waits in `tgt`.
- FETCH:
  - `take` & `im_ready`: drop data; `pc<=redirect_pc`; stay in FETCH.
  - `take` & ~`im_ready`: `tgt<=redirect_pc`; go to DRAIN.
  - `im_ready` & ~`freeze`: `if_inst=im_rdata`, `if_pc=pc`, `if_id_we=1`, `pc<=pc_add4`.
  - `im_ready` & `freeze`: `buf<=im_rdata`, `buf_pc<=pc`; go to HOLD.
  - Otherwise: hold.
- HOLD:
  - `take`: discard buffer; `pc<=redirect_pc`; go to FETCH.
  - ~`freeze`: `if_inst=buf`, `if_pc=buf_pc`, `if_id_we=1`, `pc<=pc_add4`; go to FETCH.
  - Otherwise: hold.
- DRAIN:
  - Data is never written to IF/ID.
  - On `im_ready`: `pc<=tgt`; go to FETCH.
  - A new `take` while in DRAIN overwrites `tgt` (the youngest redirect wins).
- Flushes: whenever `take=1`, `if_id_flush=1` and `id_ex_flush=1` in that cycle, and `if_id_we=0`.
- Else if `lu_hazard & ~dm_stall`: `id_ex_flush=1`, `if_id_we=0`.
- `dm_stall=1`: no outputs change state; `if_id_we=0`, both flushes 0. A pending `redirect` is acted on in the first cycle with `dm_stall=0`.
- Priority: `rst` > `dm_stall` > `redirect` > `lu_hazard` > normal advance.

## Timing
- Reset (cycle with `rst=1`):
  - `pc=RESET_PC`, state FETCH, `buf`/`tgt`/`buf_pc`=0.
  - `im_req=0`, `if_id_we=0`, both flushes 0, `if_inst`=32'h0000_0013, `if_pc=RESET_PC`.
- First cycle after reset: `im_req=1`, `im_addr=RESET_PC`.
- `rst` during DRAIN or HOLD aborts everything. The memory side must tolerate request withdrawal on reset only.
- Latency: `im_ready` with no freeze → `if_id_we` in the same cycle (combinational pass-through); `pc` advances at that edge.
- Redirect → new `im_addr` next cycle, unless the fetch is pending (then the cycle after `im_ready`).
- All outputs except `pc`, `pc_add4` and `im_addr` are combinational from state and inputs.
- Wrap-around: `pc=32'hFFFF_FFFC` advances to 0.

## Configuration
- `PC_FETCH_CTRL_PERF_EN` defined:
  - Adds outputs `perf_stall_cnt` (32) and `perf_redirect_cnt` (32), both reset to 0 and saturating at 32'hFFFF_FFFF.
  - `perf_stall_cnt` increments each cycle with ~`rst` and `if_id_we=0`.
  - `perf_redirect_cnt` increments on each `take`.
- Undefined: these ports and counters do not exist. Functional behaviour is identical either way.

## Test plan
- Reset with `RESET_PC`=32'h100, then `im_ready=1` every cycle → `im_addr` 0x100, 0x104, 0x108; `if_id_we=1` each cycle; `if_pc` matches.
- `im_ready` at 0x104 with `lu_hazard=1` for 2 cycles → HOLD; `id_ex_flush=1` for both cycles; on release, `if_inst` = buffered word, `if_pc`=0x104, next `im_addr`=0x108.
- Fetch of 0x200 pending (`im_ready=0`) plus `redirect`, `redirect_pc`=0x340 → both flushes 1; `im_addr` stays 0x200 until `im_ready`; that data is dropped; next `im_addr`=0x340.
- `redirect`=0x80 while `dm_stall=1` for 3 cycles → no flush and `pc` unchanged until `dm_stall` falls, then flushes and `im_addr`=0x80 next cycle.
- `pc`=32'hFFFF_FFFC, `im_ready=1` → `pc_add4`=0, next `im_addr`=0; `redirect_pc`=0x203 → `im_addr`=0x200.
- With `PC_FETCH_CTRL_PERF_EN`: 2 redirects and 5 stall cycles → `perf_redirect_cnt`=2, `perf_stall_cnt`=5 (plus flush cycles); both 0 after reset.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Program counter and instruction-fetch controller for the
//                5-stage RV32I core. Owns the PC, drives the instruction
//                memory request, sequences IF/ID writes and flushes under
//                memory stalls, load-use hazards and EX-stage redirects, and
//                keeps one fetched word in a skid buffer across freezes.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                im_req/im_addr      - fetch request / address (to I-mem)
//                im_ready/im_rdata   - fetch completion / instruction word
//                dm_stall            - MEM stage busy, whole pipe frozen
//                lu_hazard           - load-use hazard in ID
//                redirect/redirect_pc- EX control transfer and its target
//                pc, pc_add4         - current fetch PC and PC+4
//                if_inst/if_pc       - word and address for IF/ID
//                if_id_we            - IF/ID write enable
//                if_id_flush         - IF/ID loads a NOP
//                id_ex_flush         - ID/EX loads a bubble
//  Option      : PC_FETCH_CTRL_PERF_EN adds perf_stall_cnt and
//                perf_redirect_cnt saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    input  logic        dm_stall,
    input  logic        lu_hazard,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_add4,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_flush
`ifdef PC_FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request outstanding at pc
        ST_HOLD  = 2'd1,   // fetched word parked in the skid buffer
        ST_DRAIN = 2'd2    // stale fetch still pending, target parked in tgt
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] tgt_q, tgt_d;

    logic        freeze;
    logic        take;
    logic [31:0] target;
    logic        w_unused_bits;

    assign freeze  = dm_stall | lu_hazard;
    // A redirect seen during a memory stall is simply held off until the
    // stall clears; EX keeps presenting it.
    assign take    = redirect & ~dm_stall;
    assign target  = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits = ^redirect_pc[1:0];

    assign pc      = pc_q;
    assign im_addr = pc_q;
    assign pc_add4 = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        buf_pc_d    = buf_pc_q;
        tgt_d       = tgt_q;
        im_req      = 1'b0;
        if_inst     = C_NOP;
        if_pc       = pc_q;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (rst) begin
            if_pc = RESET_PC;
        end else begin
            if (take) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_hazard && !dm_stall) begin
                id_ex_flush = 1'b1;
            end

            case (state_q)
                ST_FETCH: begin
                    im_req = 1'b1;
                    if (take) begin
                        if (im_ready) begin
                            pc_d = target;          // wrong-path word dropped
                        end else begin
                            tgt_d   = target;       // address must stay put
                            state_d = ST_DRAIN;
                        end
                    end else if (im_ready && !freeze) begin
                        if_inst  = im_rdata;
                        if_pc    = pc_q;
                        if_id_we = 1'b1;
                        pc_d     = pc_add4;
                    end else if (im_ready) begin
                        buf_d    = im_rdata;
                        buf_pc_d = pc_q;
                        state_d  = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (take) begin
                        pc_d    = target;
                        state_d = ST_FETCH;
                    end else if (!freeze) begin
                        if_inst  = buf_q;
                        if_pc    = buf_pc_q;
                        if_id_we = 1'b1;
                        pc_d     = pc_add4;
                        state_d  = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    im_req = 1'b1;
                    if (take) begin
                        tgt_d = target;             // youngest redirect wins
                    end
                    if (im_ready) begin
                        pc_d    = take ? target : tgt_q;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            buf_q    <= 32'd0;
            buf_pc_q <= 32'd0;
            tgt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
            tgt_q    <= tgt_d;
        end
    end

`ifdef PC_FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            if (!if_id_we && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (take && redirect_cnt_q != 32'hFFFF_FFFF) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Directed, table-driven self-checking bench for
//                pc_fetch_ctrl with RESET_PC = 32'h100.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic        dm_stall;
    logic        lu_hazard;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] pc_add4;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_ex_flush;
`ifdef PC_FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    pc_fetch_ctrl #(.RESET_PC(C_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ready    (im_ready),
        .im_rdata    (im_rdata),
        .dm_stall    (dm_stall),
        .lu_hazard   (lu_hazard),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_add4     (pc_add4),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_id_we    (if_id_we),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush)
`ifdef PC_FETCH_CTRL_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic        dms;
        logic        luh;
        logic        rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic        e_iff;
        logic        e_ief;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    localparam int N_VEC = 29;
    vec_t tbl [N_VEC];

    int checks = 0;
    int errors = 0;
    int exp_stall_cnt = 0;
    int exp_redir_cnt = 0;

    function automatic vec_t mk(
        input logic rst_v, input logic rdy, input logic [31:0] rdata,
        input logic dms, input logic luh, input logic rd, input logic [31:0] rpc,
        input logic e_req, input logic [31:0] e_addr, input logic e_we,
        input logic e_iff, input logic e_ief, input logic [31:0] e_inst,
        input logic [31:0] e_ipc);
        vec_t v;
        v.rst = rst_v; v.rdy = rdy; v.rdata = rdata; v.dms = dms; v.luh = luh;
        v.rd = rd; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_we = e_we; v.e_iff = e_iff; v.e_ief = e_ief; v.e_inst = e_inst;
        v.e_ipc = e_ipc;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, compare just after,
    // and let the following rising edge commit it.
    task automatic step(input string name, input vec_t v);
        logic [31:0] exp_add4;
        @(negedge clk);
        rst = v.rst; im_ready = v.rdy; im_rdata = v.rdata; dm_stall = v.dms;
        lu_hazard = v.luh; redirect = v.rd; redirect_pc = v.rpc;
        #1;
        exp_add4 = v.e_addr + 32'd4;
        checks++;
        if (im_req !== v.e_req || im_addr !== v.e_addr || pc !== v.e_addr ||
            pc_add4 !== exp_add4 || if_id_we !== v.e_we ||
            if_id_flush !== v.e_iff || id_ex_flush !== v.e_ief ||
            if_inst !== v.e_inst || if_pc !== v.e_ipc) begin
            errors++;
            $display("FAIL %s: got req=%b addr=%h pc=%h add4=%h we=%b iff=%b ief=%b inst=%h ipc=%h exp req=%b addr=%h add4=%h we=%b iff=%b ief=%b inst=%h ipc=%h",
                     name, im_req, im_addr, pc, pc_add4, if_id_we, if_id_flush,
                     id_ex_flush, if_inst, if_pc, v.e_req, v.e_addr, exp_add4,
                     v.e_we, v.e_iff, v.e_ief, v.e_inst, v.e_ipc);
        end
        if (v.rst) begin
            exp_stall_cnt = 0;
            exp_redir_cnt = 0;
        end else begin
            if (!v.e_we) exp_stall_cnt++;
            if (v.rd && !v.dms) exp_redir_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; im_ready = 1'b0; im_rdata = 32'd0; dm_stall = 1'b0;
        lu_hazard = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

        //               rst rdy rdata         dms luh rd rpc            req addr          we iff ief inst          ipc
        tbl[0]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h100,      0, 0, 0, C_NOP,        32'h100);
        tbl[1]  = mk(0, 1, 32'hA000_0000, 0, 0, 0, 32'h0,          1, 32'h100,      1, 0, 0, 32'hA000_0000, 32'h100);
        tbl[2]  = mk(0, 1, 32'hA000_0001, 0, 0, 0, 32'h0,          1, 32'h104,      1, 0, 0, 32'hA000_0001, 32'h104);
        tbl[3]  = mk(0, 1, 32'hA000_0002, 0, 0, 0, 32'h0,          1, 32'h108,      1, 0, 0, 32'hA000_0002, 32'h108);
        // load-use hazard catches a completing fetch -> HOLD
        tbl[4]  = mk(0, 1, 32'hB000_0000, 0, 1, 0, 32'h0,          1, 32'h10C,      0, 0, 1, C_NOP,        32'h10C);
        tbl[5]  = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 32'h10C,      0, 0, 1, C_NOP,        32'h10C);
        tbl[6]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h10C,      1, 0, 0, 32'hB000_0000, 32'h10C);
        tbl[7]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h110,      0, 0, 0, C_NOP,        32'h110);
        // redirect while fetch pending -> DRAIN, stale word dropped
        tbl[8]  = mk(0, 0, 32'h0,         0, 0, 1, 32'h340,        1, 32'h110,      0, 1, 1, C_NOP,        32'h110);
        tbl[9]  = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h110,      0, 0, 0, C_NOP,        32'h110);
        tbl[10] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,          1, 32'h110,      0, 0, 0, C_NOP,        32'h110);
        tbl[11] = mk(0, 1, 32'hC000_0000, 0, 0, 0, 32'h0,          1, 32'h340,      1, 0, 0, 32'hC000_0000, 32'h340);
        // redirect held off by dm_stall for three cycles
        tbl[12] = mk(0, 0, 32'h0,         1, 0, 1, 32'h80,         1, 32'h344,      0, 0, 0, C_NOP,        32'h344);
        tbl[13] = mk(0, 0, 32'h0,         1, 0, 1, 32'h80,         1, 32'h344,      0, 0, 0, C_NOP,        32'h344);
        tbl[14] = mk(0, 0, 32'h0,         1, 0, 1, 32'h80,         1, 32'h344,      0, 0, 0, C_NOP,        32'h344);
        tbl[15] = mk(0, 1, 32'h0,         0, 0, 1, 32'h80,         1, 32'h344,      0, 1, 1, C_NOP,        32'h344);
        tbl[16] = mk(0, 1, 32'hD000_0000, 0, 0, 0, 32'h0,          1, 32'h80,       1, 0, 0, 32'hD000_0000, 32'h80);
        // misaligned target has its low bits cleared
        tbl[17] = mk(0, 1, 32'h0,         0, 0, 1, 32'h203,        1, 32'h84,       0, 1, 1, C_NOP,        32'h84);
        tbl[18] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h200,      0, 0, 0, C_NOP,        32'h200);
        // two redirects while draining: the younger one wins
        tbl[19] = mk(0, 0, 32'h0,         0, 0, 1, 32'h400,        1, 32'h200,      0, 1, 1, C_NOP,        32'h200);
        tbl[20] = mk(0, 1, 32'h0,         0, 0, 1, 32'h500,        1, 32'h200,      0, 1, 1, C_NOP,        32'h200);
        // redirect while a word sits in HOLD discards it
        tbl[21] = mk(0, 1, 32'hE000_0000, 0, 1, 0, 32'h0,          1, 32'h500,      0, 0, 1, C_NOP,        32'h500);
        tbl[22] = mk(0, 0, 32'h0,         0, 1, 1, 32'h600,        0, 32'h500,      0, 1, 1, C_NOP,        32'h500);
        tbl[23] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h600,      0, 0, 0, C_NOP,        32'h600);
        // wrap-around at the top of the address space
        tbl[24] = mk(0, 1, 32'h0,         0, 0, 1, 32'hFFFF_FFFC,  1, 32'h600,      0, 1, 1, C_NOP,        32'h600);
        tbl[25] = mk(0, 1, 32'hF000_0000, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 1, 0, 0, 32'hF000_0000, 32'hFFFF_FFFC);
        // reset in the middle of a drain aborts it
        tbl[26] = mk(0, 0, 32'h0,         0, 0, 1, 32'h700,        1, 32'h0,        0, 1, 1, C_NOP,        32'h0);
        tbl[27] = mk(1, 0, 32'h0,         0, 0, 1, 32'h700,        0, 32'h0,        0, 0, 0, C_NOP,        32'h100);
        tbl[28] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 32'h100,      0, 0, 0, C_NOP,        32'h100);

        // bring pc out of its unknown power-up state
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // memory stall catches a completing fetch; word kept in HOLD until
        // both the stall and a following hazard have cleared
        step("dms_hold_in",  mk(0, 1, 32'h1111_1111, 1, 0, 0, 32'h0, 1, 32'h100, 0, 0, 0, C_NOP, 32'h100));
        step("dms_hold_luh", mk(0, 0, 32'h0,         1, 1, 0, 32'h0, 0, 32'h100, 0, 0, 0, C_NOP, 32'h100));
        step("hold_luh",     mk(0, 0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h100, 0, 0, 1, C_NOP, 32'h100));
        step("hold_release", mk(0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 32'h100, 1, 0, 0, 32'h1111_1111, 32'h100));
        step("after_hold",   mk(0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 32'h104, 0, 0, 0, C_NOP, 32'h104));

`ifdef PC_FETCH_CTRL_PERF_EN
        @(negedge clk);
        #1;
        checks++;
        if (perf_stall_cnt !== 32'(exp_stall_cnt)) begin
            errors++;
            $display("FAIL perf_stall_cnt: got %0d exp %0d", perf_stall_cnt, exp_stall_cnt);
        end
        checks++;
        if (perf_redirect_cnt !== 32'(exp_redir_cnt)) begin
            errors++;
            $display("FAIL perf_redirect_cnt: got %0d exp %0d", perf_redirect_cnt, exp_redir_cnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
